md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Iterative 16-bit multiply/divide unit in the execute stage, directly downstream of the register file.
//  Consumes RF read data RD1/RD2 as operands; its RESULT feeds the RF write-data mux (WD).
//  Operands are captured on START; BUSY stalls the CPU until DONE, when RESULT is written back.
//  Shift-add multiply and restoring divide, one bit per clock.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; iteration count = WIDTH
//  CNT_W  5   iteration counter width; must hold the value WIDTH
// PORTS
//  CLK     in   1      clock, rising edge
//  CLR     in   1      synchronous reset, active-high
//  START   in   1      request; accepted only when state==IDLE
//  OP      in   3      [1:0] 00=MUL low, 01=MUL high, 10=DIV quotient, 11=DIV remainder; [2]=signed
//  A       in   WIDTH  operand A (from RF RD1): multiplicand / dividend
//  B       in   WIDTH  operand B (from RF RD2): multiplier / divisor
//  BUSY    out  1      high while state!=IDLE
//  DONE    out  1      one-cycle pulse; RESULT valid in this cycle
//  RESULT  out  WIDTH  selected result; held until the next accepted START or CLR
//  DZ      out  1      divide-by-zero flag for the last operation; held like RESULT
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous, active-high (CLR), sampled on the CLK rising edge.
//    CLR=1 -> next edge: state=IDLE, BUSY=0, DONE=0, RESULT=0, DZ=0, counter=0.
//  - States: IDLE -> RUN on START=1. RUN -> DONE when counter reaches WIDTH. DONE -> IDLE unconditionally.
//  - START edge (cycle 0): A, B and OP are latched, counter=0, and the 2*WIDTH accumulator is cleared.
//    RF outputs may change afterwards without effect.
//  - RUN: exactly WIDTH cycles (1..16), one bit processed per cycle. DONE occurs in cycle WIDTH+1 (17).
//    Total latency from START edge to DONE = 17 cycles. START during RUN or DONE is ignored (no queueing).
//  - MUL: 32-bit product P=A*B. OP=00 -> P[15:0]; OP=01 -> P[31:16].
//  - DIV: restoring divide. OP=10 -> quotient; OP=11 -> remainder.
//  - B==0 on DIV: DZ=1, quotient=16'hFFFF, remainder=A; full 17-cycle latency is retained.
//    DZ=0 for every MUL.
//  - RESULT and DZ update on the edge that enters DONE, then hold through IDLE.
//  - CLR during RUN aborts the operation: next edge gives the reset values, with no DONE pulse.
//  - CLR and START in the same cycle: CLR wins and START is dropped.
//  - Back-to-back operation: START may be asserted in the cycle after DONE (state IDLE).
//    A START in the DONE cycle is ignored.
// CONFIGURATION
//  MD_SIGNED_EN defined:
//   - OP[2]=1 selects two's-complement operation: operands are converted to magnitudes and the unsigned core runs.
//   - Result sign is fixed in the DONE transition; latency is unchanged.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 16'h8000 / 16'hFFFF -> quotient 16'h8000, remainder 0.
//   - Signed divide by zero: quotient 16'hFFFF, remainder = A, DZ=1.
//  MD_SIGNED_EN undefined:
//   - OP[2] is ignored and all operations are unsigned; no sign-fix logic is synthesised.
// TESTING
//  1 CLR=1 for 3 cycles, then 0 -> BUSY=0, DONE=0, RESULT=0, DZ=0; START held 0 -> no state change.
//  2 A=16'h0123, B=16'h0010, OP=000, START 1 cycle -> BUSY high 17 cycles; DONE exactly at cycle 17; RESULT=16'h1230.
//    Repeat with OP=001 and A=B=16'hFFFF -> RESULT=16'hFFFE.
//  3 A=16'd1000, B=16'd7: OP=010 -> RESULT=16'd142; OP=011 -> RESULT=16'd6; DZ=0.
//    Change A/B during RUN -> result unchanged.
//  4 A=16'h1234, B=0, OP=010 -> RESULT=16'hFFFF, DZ=1. OP=011 -> RESULT=16'h1234, DZ=1.
//    Next MUL -> DZ=0.
//  5 START pulsed again at cycles 5 and 17 -> ignored: one DONE, result unchanged.
//    CLR at cycle 8 of a new op -> next edge BUSY=0, RESULT=0, no DONE pulse.
//  6 (MD_SIGNED_EN) A=16'hFFF9 (-7), B=16'd2: OP=110 -> 16'hFFFD; OP=111 -> 16'hFFFF; OP=100 -> 16'hFFF2.
//    Without MD_SIGNED_EN, OP=110 gives the unsigned quotient 16'h7FFC.

Source files
------------

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// Optional macro MD_SIGNED_EN enables two's-complement operation selected by OP[2].
module md_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_dz
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [1:0]           r_op;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;
  logic                 r_dz;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_step;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_div_idx;
  logic [WIDTH-1:0]     w_acc_hi;
  logic [WIDTH-1:0]     w_acc_lo;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [2*WIDTH-1:0]   w_fix;
  logic [WIDTH-1:0]     w_final;
  logic                 w_dz;

`ifdef MD_SIGNED_EN
  logic                 r_signed;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic                 w_neg_a;
  logic                 w_neg_b;
  assign w_neg_a = i_op[2] & i_a[WIDTH-1];
  assign w_neg_b = i_op[2] & i_b[WIDTH-1];
`else
  logic                 w_unused_op2;
  assign w_unused_op2 = i_op[2];
`endif

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH));
  assign w_step   = (r_state == S_RUN) && !w_last;
  assign w_dz     = r_op[1] && (r_b == WIDTH'(0));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nx = S_RUN;
        else         w_state_nx = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(WIDTH)) w_state_nx = S_DONE;
        else                        w_state_nx = S_RUN;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Multiply keeps the partial product in the high half and shifts right;
  // divide keeps the partial remainder high and shifts quotient bits in low.
  always_comb begin
    w_idx      = r_cnt[IDX_W-1:0];
    w_div_idx  = IDX_W'(WIDTH - 1) - w_idx;
    w_acc_hi   = r_acc[2*WIDTH-1:WIDTH];
    w_acc_lo   = r_acc[WIDTH-1:0];
    w_sum      = {1'b0, w_acc_hi} + {1'b0, r_a};
    w_shift    = {w_acc_hi, r_a[w_div_idx]};
    w_trial    = w_shift - {1'b0, r_b};
    w_acc_step = r_acc;
    if (!r_op[1]) begin
      if (r_b[w_idx]) w_acc_step = {w_sum, w_acc_lo[WIDTH-1:1]};
      else            w_acc_step = {1'b0, w_acc_hi, w_acc_lo[WIDTH-1:1]};
    end else begin
      if (!w_trial[WIDTH]) w_acc_step = {w_trial[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b1};
      else                 w_acc_step = {w_shift[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // A zero divisor yields an all-ones quotient and remainder = |A| from the core itself.
  always_comb begin
    w_fix = r_acc;
`ifdef MD_SIGNED_EN
    if (r_signed) begin
      if (!r_op[1]) begin
        if (r_neg_a ^ r_neg_b) w_fix = -r_acc;
        else                   w_fix = r_acc;
      end else begin
        if ((r_neg_a ^ r_neg_b) && !w_dz) w_fix[WIDTH-1:0] = -w_acc_lo;
        else                              w_fix[WIDTH-1:0] = w_acc_lo;
        if (r_neg_a) w_fix[2*WIDTH-1:WIDTH] = -w_acc_hi;
        else         w_fix[2*WIDTH-1:WIDTH] = w_acc_hi;
      end
    end else begin
      w_fix = r_acc;
    end
`endif
    if (r_op[0]) w_final = w_fix[2*WIDTH-1:WIDTH];
    else         w_final = w_fix[WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_W'(0);
      r_a      <= WIDTH'(0);
      r_b      <= WIDTH'(0);
      r_op     <= 2'b00;
      r_acc    <= (2*WIDTH)'(0);
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= WIDTH'(0);
      r_dz     <= 1'b0;
`ifdef MD_SIGNED_EN
      r_signed <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
      if (w_accept) begin
        r_cnt <= CNT_W'(0);
        r_acc <= (2*WIDTH)'(0);
        r_op  <= i_op[1:0];
`ifdef MD_SIGNED_EN
        r_signed <= i_op[2];
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_a      <= w_neg_a ? (WIDTH'(0) - i_a) : i_a;
        r_b      <= w_neg_b ? (WIDTH'(0) - i_b) : i_b;
`else
        r_a      <= i_a;
        r_b      <= i_b;
`endif
      end else if (w_step) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_result <= w_final;
        r_dz     <= w_dz;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_dz     = r_dz;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; signed vectors follow MD_SIGNED_EN.
module tb_md_unit;

  logic        clk;
  logic        i_clr;
  logic        i_start;
  logic [2:0]  i_op;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_dz;

  int checks;
  int errors;

  md_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .i_clk   (clk),
    .i_clr   (i_clr),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_result(o_result),
    .o_dz    (o_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation, scrambling operands after the START edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_r, input logic exp_dz,
                       input bit inject);
    int n;
    int busy_low;
    int extra_done;
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_a = ~a; i_b = ~b;
    n = 0; busy_low = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 4) begin
        i_start = 1'b1; i_op = 3'b000; i_a = 16'h0002; i_b = 16'h0003;
      end
      if (inject && n == 5) i_start = 1'b0;
      if (o_done) break;
      if (!o_busy) busy_low++;
    end
    check_val({tag, "_latency"}, n, 32'd17);
    check_val({tag, "_busy_run"}, busy_low, 32'd0);
    check_val({tag, "_busy_done"}, {31'd0, o_busy}, 32'd1);
    check_val({tag, "_result"}, {16'd0, o_result}, {16'd0, exp_r});
    check_val({tag, "_dz"}, {31'd0, o_dz}, {31'd0, exp_dz});
    if (inject) i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check_val({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    check_val({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    check_val({tag, "_hold"}, {16'd0, o_result}, {16'd0, exp_r});
    if (inject) begin
      extra_done = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (o_done || o_busy) extra_done++;
      end
      check_val({tag, "_no_second_op"}, extra_done, 32'd0);
      check_val({tag, "_hold_late"}, {16'd0, o_result}, {16'd0, exp_r});
    end
  endtask

  initial begin
    int dn;
    checks = 0; errors = 0;
    i_clr = 1'b1; i_start = 1'b0; i_op = 3'b000; i_a = 16'h0000; i_b = 16'h0000;
    repeat (3) @(posedge clk);
    #1; i_clr = 1'b0;
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    check_val("rst_result", {16'd0, o_result}, 32'd0);
    check_val("rst_dz", {31'd0, o_dz}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_no_start", {31'd0, o_busy}, 32'd0);

    do_op("mul_lo", 3'b000, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0);
    do_op("mul_hi", 3'b001, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
    do_op("div_q", 3'b010, 16'd1000, 16'd7, 16'd142, 1'b0, 1'b0);
    do_op("div_r", 3'b011, 16'd1000, 16'd7, 16'd6, 1'b0, 1'b0);
    do_op("dz_q", 3'b010, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    do_op("dz_r", 3'b011, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0);
    do_op("mul_dz_clr", 3'b000, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
    do_op("ignore_start", 3'b010, 16'd1000, 16'd7, 16'd142, 1'b0, 1'b1);

    // Abort in the middle of a multiply.
    @(negedge clk);
    i_op = 3'b000; i_a = 16'h0101; i_b = 16'h0202; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (7) @(posedge clk);
    #1; i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    check_val("abort_busy", {31'd0, o_busy}, 32'd0);
    check_val("abort_result", {16'd0, o_result}, 32'd0);
    check_val("abort_done", {31'd0, o_done}, 32'd0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_done) dn++;
    end
    check_val("abort_no_done", dn, 32'd0);

    // CLR and START together: START dropped.
    @(negedge clk);
    i_clr = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0; i_start = 1'b0;
    check_val("clr_wins", {31'd0, o_busy}, 32'd0);

`ifdef MD_SIGNED_EN
    do_op("s_div_q", 3'b110, 16'hFFF9, 16'd2, 16'hFFFD, 1'b0, 1'b0);
    do_op("s_div_r", 3'b111, 16'hFFF9, 16'd2, 16'hFFFF, 1'b0, 1'b0);
    do_op("s_mul", 3'b100, 16'hFFF9, 16'd2, 16'hFFF2, 1'b0, 1'b0);
    do_op("s_ovf_q", 3'b110, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b0);
    do_op("s_ovf_r", 3'b111, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    do_op("s_dz_q", 3'b110, 16'hFFF9, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    do_op("s_dz_r", 3'b111, 16'hFFF9, 16'h0000, 16'hFFF9, 1'b1, 1'b0);
`else
    do_op("u_div_q", 3'b110, 16'hFFF9, 16'd2, 16'h7FFC, 1'b0, 1'b0);
    do_op("u_div_r", 3'b111, 16'hFFF9, 16'd2, 16'h0001, 1'b0, 1'b0);
    do_op("u_mul", 3'b100, 16'hFFF9, 16'd2, 16'hFFF2, 1'b0, 1'b0);
    do_op("u_ovf_q", 3'b110, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    do_op("u_ovf_r", 3'b111, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
